alu4_arbiter: RTL and testbench
===============================

Name: alu4_arbiter

Overview:
- Shares a single `alu4` combinational ALU (4-bit; arithmetic/logic selected by mode plus a 2-bit op) between two requesters.
- Round-robin arbitration selects one request, registers its operands into the `alu4` instance, and presents the result on a valid/ready response port tagged with the requester ID.
- Sits between two client engines and the shared ALU. It is the only driver of the ALU inputs.

Parameters:
- CNT_W, 8, width of the completed-operation counter op_count (saturating).
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  4 each  requester 0 operands.
- req0_mode  input  1  0 = arithmetic, 1 = logic.
- req0_op  input  2  operation select.
- req1_valid, req1_ready, req1_a, req1_b, req1_mode, req1_op  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_y  output  4  ALU result.
- rsp_id  output  1  requester that issued the result.
- busy  output  1  high in EXEC or RESP.
- op_count  output  CNT_W  number of completed response handshakes; saturates at all-ones.

Behaviour:
- Operation encoding (4-bit, wrap modulo 16):
  - mode=0, op: 00 a+b; 01 a-b; 10 a-1; 11 b-1.
  - mode=1, op: 00 a&b; 01 a|b; 10 ~a; 11 ~b.
  - Computation is done by an instantiated `alu4`. The arbiter contains no duplicate ALU logic.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with valid; if both are valid, the requester indicated by rr_ptr.
  - req<grant>_ready = 1 combinationally in the same cycle. The other ready = 0.
  - On a handshake: latch a, b, mode, op and the grant id into operand registers; go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - The operand registers drive `alu4`. At the clock edge, y is registered into rsp_y, rsp_id is loaded, rsp_valid is set to 1, and the FSM goes to RESP.
- RESP:
  - rsp_valid = 1. rsp_y and rsp_id are held stable until rsp_ready = 1.
  - On the handshake: rsp_valid -> 0; rr_ptr -> ~rsp_id (the other requester gets priority); op_count increments unless it is all-ones; go to IDLE.
- Both req*_ready = 0 in EXEC and RESP. Requesters hold their inputs until they see ready.
- Latency:
  - Request accepted in cycle N -> rsp_valid is high in cycle N+2.
  - Minimum issue interval is 3 cycles (accept, execute, respond with immediate rsp_ready).
- A request valid in the same cycle as a response handshake is not accepted until the next cycle (IDLE). There is no bypass.
- rr_ptr changes only on a response handshake. A single requester can be served back-to-back if the other is idle.
- Reset (any state, including mid-operation):
  - State -> IDLE; rsp_valid = 0; rsp_y = 0; rsp_id = 0; operand registers = 0; rr_ptr = RR_INIT; op_count = 0.
  - The pending operation is discarded and no response is produced.
  - req*_ready forced to 0 while rst = 1.
- busy = 1 exactly when state is EXEC or RESP.

Test Plan:
- Basic arithmetic:
  - req0 a=3, b=5, mode=0, op=00 with rsp_ready=1 -> req0_ready in cycle N; rsp_valid at N+2 with rsp_y=8, rsp_id=0; op_count=1.
  - Also 3-5 -> rsp_y=14; a=0, op=10 -> rsp_y=15 (wrap).
- Logic sweep:
  - a=4'b1100, b=4'b1010, mode=1, op 00/01/10/11 -> 1000, 1110, 0011, 0101 respectively.
- Contention:
  - RR_INIT=0, both valid continuously for 4 operations -> rsp_id sequence 0, 1, 0, 1; each response carries its own requester's operands.
- Backpressure:
  - rsp_ready=0 for 5 cycles in RESP -> rsp_y and rsp_id stable; both ready=0; no new accept.
  - Release rsp_ready -> one handshake; op_count increments once.
- Reset mid-operation:
  - Assert rst in EXEC -> next cycle IDLE, rsp_valid=0, op_count=0.
  - No response is emitted for the aborted operation; the next request is served normally.
- Saturation:
  - CNT_W=2, 5 completed operations -> op_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters; accept -> result in 2 cycles.
// Response is held until rsp_ready; no request is accepted while an operation is in flight.

module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       mode,
  input  logic [1:0] op,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case ({mode, op})
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a - 4'd1;
      3'b011:  y = b - 4'd1;
      3'b100:  y = a & b;
      3'b101:  y = a | b;
      3'b110:  y = ~a;
      3'b111:  y = ~b;
      default: y = 4'h0;
    endcase
  end
endmodule

module alu4_arbiter #(
  parameter int CNT_W   = 8,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req0_mode,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic             req1_mode,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_y,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_mode_q, op_mode_d, op_id_q, op_id_d;
  logic [1:0]       op_op_q, op_op_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [3:0]       rsp_y_q, rsp_y_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             gnt_id;
  logic [3:0]       alu_y;

  alu4 u_alu (
    .a    (op_a_q),
    .b    (op_b_q),
    .mode (op_mode_q),
    .op   (op_op_q),
    .y    (alu_y)
  );

  // Pointer only matters when both requesters compete.
  assign gnt_id = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_mode_d   = op_mode_q;
    op_op_d     = op_op_q;
    op_id_d     = op_id_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = !gnt_id;
          req1_ready = gnt_id;
          op_a_d     = gnt_id ? req1_a    : req0_a;
          op_b_d     = gnt_id ? req1_b    : req0_b;
          op_mode_d  = gnt_id ? req1_mode : req0_mode;
          op_op_d    = gnt_id ? req1_op   : req0_op;
          op_id_d    = gnt_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d     = alu_y;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = ~rsp_id_q;
          if (!(&op_count_q)) op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= 4'h0;
      op_b_q      <= 4'h0;
      op_mode_q   <= 1'b0;
      op_op_q     <= 2'b00;
      op_id_q     <= 1'b0;
      rr_ptr_q    <= 1'(RR_INIT);
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 4'h0;
      rsp_id_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_mode_q   <= op_mode_d;
      op_op_q     <= op_op_d;
      op_id_q     <= op_id_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q == EXEC) || (state_q == RESP);
endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed-vector bench for alu4_arbiter, built with a 2-bit op counter to reach saturation quickly.
module tb_alu4_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_mode;
  logic [3:0] req0_a, req0_b;
  logic [1:0] req0_op;
  logic       req1_valid, req1_ready, req1_mode;
  logic [3:0] req1_a, req1_b;
  logic [1:0] req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_y;
  logic [1:0] op_count;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  alu4_arbiter #(.CNT_W(2), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue one op and return the response; to=1 if either wait ran out.
  task automatic run_op(input bit id, input logic [3:0] a, input logic [3:0] b, input logic m,
                        input logic [1:0] op, output logic [3:0] y, output logic rid,
                        output int lat, output bit to);
    int n;
    n = 0; to = 1'b0; lat = 0; y = 4'h0; rid = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m; req0_op = op;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick(); #1; n++;
    end
    if (n >= 20) to = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick(); lat++;
    end
    if (lat >= 10) to = 1'b1;
    y = rsp_y;
    rid = rsp_id;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    #1;
    vectors++;
    if ({rsp_valid, rsp_y, rsp_id, busy, op_count} !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_state: got valid/y/id/busy/cnt=%b expected 000000000",
               {rsp_valid, rsp_y, rsp_id, busy, op_count});
    end
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready_forced: got %b expected 00", {req0_ready, req1_ready});
    end
    apply_reset();
  endtask

  task automatic test_arith();
    logic [3:0] y; logic rid; int lat; bit to;
    logic [3:0] ta [4] = '{4'd3, 4'd3, 4'd0, 4'd7};
    logic [3:0] tb [4] = '{4'd5, 4'd5, 4'd9, 4'd0};
    logic [1:0] top[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] ty [4] = '{4'd8, 4'd14, 4'd15, 4'd15};
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ta[i], tb[i], 1'b0, top[i], y, rid, lat, to);
      vectors++;
      if (to || y !== ty[i] || rid !== 1'b0 || lat != 2) begin
        miscompares++;
        $display("FAIL arith_%0d: got y=%0d id=%b lat=%0d to=%0d expected y=%0d id=0 lat=2 to=0",
                 i, y, rid, lat, to, ty[i]);
      end
      if (i == 0) begin
        vectors++;
        if (op_count !== 2'd1) begin
          miscompares++;
          $display("FAIL arith_op_count: got %0d expected 1", op_count);
        end
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0] y; logic rid; int lat; bit to;
    logic [3:0] ty[4] = '{4'b1000, 4'b1110, 4'b0011, 4'b0101};
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 4'b1100, 4'b1010, 1'b1, 2'(i), y, rid, lat, to);
      vectors++;
      if (to || y !== ty[i] || rid !== 1'b1) begin
        miscompares++;
        $display("FAIL logic_op%0d: got y=%b id=%b to=%0d expected y=%b id=1 to=0",
                 i, y, rid, to, ty[i]);
      end
    end
  endtask

  task automatic test_contention();
    int n; int last;
    logic exp_id[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    rsp_ready = 1'b1;
    req0_a = 4'd1; req0_b = 4'd2; req0_mode = 1'b0; req0_op = 2'b00;
    req1_a = 4'd6; req1_b = 4'd1; req1_mode = 1'b0; req1_op = 2'b01;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin
        tick(); n++;
      end
      vectors++;
      if (n >= 20 || rsp_id !== exp_id[k] || rsp_y !== (exp_id[k] ? 4'd5 : 4'd3)) begin
        miscompares++;
        $display("FAIL contention_%0d: got id=%b y=%0d expected id=%b y=%0d",
                 k, rsp_id, rsp_y, exp_id[k], exp_id[k] ? 5 : 3);
      end
      if (k > 0) begin
        vectors++;
        if (cyc - last != 3) begin
          miscompares++;
          $display("FAIL contention_gap_%0d: got %0d cycles expected 3", k, cyc - last);
        end
      end
      last = cyc;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    rsp_ready = 1'b0;
    req1_a = 4'b1010; req1_b = 4'b0011; req1_mode = 1'b1; req1_op = 2'b00;
    req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_grant: got ready0/1=%b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    req0_a = 4'd5; req0_b = 4'd6; req0_mode = 1'b0; req0_op = 2'b00;
    req0_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick(); n++;
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if ({rsp_valid, rsp_y, rsp_id, req0_ready, req1_ready, busy, op_count} !== 11'b1_0010_1_00_1_00) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got v/y/id/r0/r1/busy/cnt=%b expected 10010100100",
                 c, {rsp_valid, rsp_y, rsp_id, req0_ready, req1_ready, busy, op_count});
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    vectors++;
    if ({rsp_valid, op_count, req0_ready} !== 4'b0_01_1) begin
      miscompares++;
      $display("FAIL bp_release: got valid/cnt/ready0=%b expected 0011", {rsp_valid, op_count, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick(); n++;
    end
    vectors++;
    if (n >= 10 || rsp_y !== 4'd11 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next: got y=%0d id=%b expected y=11 id=0", rsp_y, rsp_id);
    end
    tick();
    vectors++;
    if (op_count !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_count: got %0d expected 2", op_count);
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] y; logic rid; int lat; bit to;
    apply_reset();
    rsp_ready = 1'b1;
    run_op(1'b0, 4'd1, 4'd1, 1'b0, 2'b00, y, rid, lat, to);
    req0_a = 4'd9; req0_b = 4'd4; req0_mode = 1'b0; req0_op = 2'b00;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_in_exec: got busy=%b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({busy, rsp_valid, op_count} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midop_reset: got busy/valid/cnt=%b expected 0000", {busy, rsp_valid, op_count});
    end
    req1_valid = 1'b1;
    #1;
    vectors++;
    if (req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_ready_in_rst: got %b expected 0", req1_ready);
    end
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_no_rsp: got rsp_valid=%b expected 0", rsp_valid);
    end
    run_op(1'b1, 4'd2, 4'd2, 1'b0, 2'b00, y, rid, lat, to);
    vectors++;
    if (to || y !== 4'd4 || rid !== 1'b1 || op_count !== 2'd1) begin
      miscompares++;
      $display("FAIL midop_next: got y=%0d id=%b cnt=%0d to=%0d expected y=4 id=1 cnt=1 to=0",
               y, rid, op_count, to);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] y; logic rid; int lat; bit to;
    logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(1'(i), 4'(i), 4'd1, 1'b0, 2'b00, y, rid, lat, to);
      vectors++;
      if (to || op_count !== exp_cnt[i]) begin
        miscompares++;
        $display("FAIL sat_%0d: got cnt=%0d to=%0d expected cnt=%0d to=0", i, op_count, to, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0; req0_mode = 1'b0; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_mode = 1'b0; req1_op = 2'b00;
    test_reset();
    test_arith();
    test_logic();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
